// File: rtl/xsleena_pkg.sv
// Shared types and requester indices for the Xain'd Sleena ROM fetch arbiters.
package xsleena_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  localparam int REQ_OBJ   = 0;
  localparam int REQ_BACK1 = 1;
  localparam int REQ_BACK2 = 2;
  localparam int REQ_MAP   = 3;

endpackage

// File: rtl/xsleena_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after rr_ptr,
// wrapping modulo NREQ.
module xsleena_rr_pick
  import xsleena_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            found,
  output logic [IW-1:0]   index
);

  // Scan from the farthest offset down so the nearest hit is written last and wins.
  always_comb begin
    logic [IW:0] pos;
    found = 1'b0;
    index = '0;
    pos   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
      if (req[pos[IW-1:0]]) begin
        found = 1'b1;
        index = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/xsleena_rom_fetch_arbiter.sv
// Round-robin arbiter sharing one SDRAM read port among the OBJ/BACK1/BACK2/MAP fetchers.
// Optional per-requester last-address hit cache: define XSLEENA_ROMARB_HITCACHE_EN.
module xsleena_rom_fetch_arbiter
  import xsleena_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 22,
  parameter int DW   = 16
) (
  input  logic               clk,
  input  logic               RSTn,
  input  logic [NREQ-1:0]    req_cs,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ok,
  output logic [DW-1:0]      req_data,
  output logic               sdr_req,
  output logic [AW-1:0]      sdr_addr,
  input  logic               sdr_ack,
  input  logic               sdr_rdy,
  input  logic [DW-1:0]      sdr_din,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t    state, state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          hit;
  logic [AW-1:0] addr_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*AW +: AW];
  end

  xsleena_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req_cs),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .index  (pick_idx)
  );

`ifdef XSLEENA_ROMARB_HITCACHE_EN
  logic [NREQ-1:0] c_vld;
  logic [AW-1:0]   c_addr [NREQ];
  logic [DW-1:0]   c_data [NREQ];

  assign hit = pick_found && c_vld[pick_idx] && (c_addr[pick_idx] == addr_a[pick_idx]);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)               c_vld        <= '0;
    else if (state == DONE)  c_vld[grant] <= 1'b1;
  end

  // Entry contents are qualified by c_vld, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == DONE) begin
      c_addr[grant] <= sdr_addr;
      c_data[grant] <= req_data;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = hit ? DONE : ISSUE;
      ISSUE:   if (sdr_ack)    state_nxt = sdr_rdy ? DONE : WAIT;
      WAIT:    if (sdr_rdy)    state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // sdr_addr doubles as the latched grant address used for the staleness check in DONE.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      sdr_req  <= 1'b0;
      sdr_addr <= '0;
      req_ok   <= '0;
      req_data <= '0;
      rr_ptr   <= '0;
      grant    <= '0;
    end else begin
      req_ok <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant    <= pick_idx;
            sdr_addr <= addr_a[pick_idx];
            sdr_req  <= !hit;
`ifdef XSLEENA_ROMARB_HITCACHE_EN
            if (hit) req_data <= c_data[pick_idx];
`endif
          end
        end
        ISSUE: begin
          if (sdr_ack) begin
            sdr_req <= 1'b0;
            if (sdr_rdy) req_data <= sdr_din;
          end
        end
        WAIT: begin
          if (sdr_rdy) req_data <= sdr_din;
        end
        DONE: begin
          if (req_cs[grant] && (addr_a[grant] == sdr_addr)) req_ok[grant] <= 1'b1;
          rr_ptr <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
